lsu_ctrl: RTL and testbench

//  Load/store initiator driving the data-memory port (wr_en/rd_en/size/sign_ext/addr/in_data/out_data).

---
 rtl/lsu_ctrl_pkg.sv | 26 ++
 rtl/lsu_align.sv | 30 +++
 rtl/lsu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared size codes, FSM encoding and attribute struct for the load/store controller.
// LSU_MISALIGN_SPLIT_EN adds the SPLIT state used for byte-wise misaligned accesses.
package lsu_ctrl_pkg;

    localparam int unsigned LSU_DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
`ifdef LSU_MISALIGN_SPLIT_EN
        ST_SPLIT  = 2'b10,
`endif
        ST_RESP   = 2'b11
    } state_e;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sign;
    } req_attr_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational access checks (invalid size, misalignment) and sign/zero extension
// of right-aligned load data to the full data width.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [1:0]            size,
    input  logic [1:0]            addr_lo,
    input  logic                  sign,
    input  logic [LSU_DATA_W-1:0] raw_data,
    output logic                  invalid_c,
    output logic                  misalign_c,
    output logic [LSU_DATA_W-1:0] ext_data_c
);

    always_comb begin
        invalid_c  = (size == 2'b11);
        misalign_c = 1'b0;
        ext_data_c = raw_data;
        case (size)
            SZ_BYTE: ext_data_c = {{24{sign & raw_data[7]}}, raw_data[7:0]};
            SZ_HALF: begin
                misalign_c = addr_lo[0];
                ext_data_c = {{16{sign & raw_data[15]}}, raw_data[15:0]};
            end
            SZ_WORD: misalign_c = (addr_lo != 2'b00);
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one request at a time and sequences it onto the data-memory port.
// Define LSU_MISALIGN_SPLIT_EN to service misaligned half/word accesses as single-byte accesses.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [1:0]        mem_size,
    output logic              mem_sign_ext,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state;
    req_attr_t         attr_q;
    logic [1:0]        al_size;
    logic [DATA_W-1:0] al_rdata;
    logic              invalid;
    logic              misalign;
    logic              req_err;
    logic [DATA_W-1:0] ext_data;

    // Checks look at the incoming request; extension uses the latched attributes.
    assign al_size = (state == ST_IDLE) ? req_size : attr_q.size;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        idx_q;
    logic [1:0]        last_idx;
    logic [DATA_W-1:0] asm_data;

    // resp_rdata doubles as the little-endian assembly buffer during SPLIT.
    assign last_idx = (attr_q.size == SZ_HALF) ? 2'd1 : 2'd3;
    assign asm_data = resp_rdata | (DATA_W'(mem_rdata[7:0]) << {idx_q, 3'b000});
    assign al_rdata = (state == ST_SPLIT) ? asm_data : mem_rdata;
    assign req_err  = invalid;
`else
    assign al_rdata = mem_rdata;
    assign req_err  = invalid | misalign;
`endif

    lsu_align u_align (
        .size       (al_size),
        .addr_lo    (req_addr[1:0]),
        .sign       (attr_q.sign),
        .raw_data   (al_rdata),
        .invalid_c  (invalid),
        .misalign_c (misalign),
        .ext_data_c (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            attr_q       <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_size     <= '0;
            mem_sign_ext <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            wdata_q      <= '0;
            idx_q        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        attr_q    <= '{we: req_we, size: req_size, sign: req_sign};
                        req_ready <= 1'b0;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= ST_RESP;
                        end
`ifdef LSU_MISALIGN_SPLIT_EN
                        else if (misalign) begin
                            wdata_q      <= req_wdata;
                            idx_q        <= '0;
                            mem_wr_en    <= req_we;
                            mem_rd_en    <= ~req_we;
                            mem_size     <= SZ_BYTE;
                            mem_sign_ext <= 1'b0;
                            mem_addr     <= req_addr;
                            mem_wdata    <= DATA_W'(req_wdata[7:0]);
                            state        <= ST_SPLIT;
                        end
`endif
                        else begin
                            mem_wr_en    <= req_we;
                            mem_rd_en    <= ~req_we;
                            mem_size     <= req_size;
                            mem_sign_ext <= req_sign;
                            mem_addr     <= req_addr;
                            mem_wdata    <= req_wdata;
                            state        <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_wr_en    <= 1'b0;
                    mem_rd_en    <= 1'b0;
                    mem_size     <= '0;
                    mem_sign_ext <= 1'b0;
                    mem_addr     <= '0;
                    mem_wdata    <= '0;
                    resp_rdata   <= attr_q.we ? '0 : ext_data;
                    resp_err     <= 1'b0;
                    resp_valid   <= 1'b1;
                    state        <= ST_RESP;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ST_SPLIT: begin
                    if (!attr_q.we) begin
                        resp_rdata <= asm_data;
                    end
                    if (idx_q == last_idx) begin
                        mem_wr_en  <= 1'b0;
                        mem_rd_en  <= 1'b0;
                        mem_addr   <= '0;
                        mem_wdata  <= '0;
                        resp_rdata <= attr_q.we ? '0 : ext_data;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        idx_q     <= 2'(idx_q + 2'd1);
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_wdata <= DATA_W'(wdata_q[{2'(idx_q + 2'd1), 3'b000} +: 8]);
                    end
                end
`endif
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed plus random requests against a byte-array reference model,
// with scoreboards for memory-port accesses and responses.
module tb_lsu_ctrl;

    localparam logic [1:0] B   = 2'b00;
    localparam logic [1:0] H   = 2'b01;
    localparam logic [1:0] W   = 2'b10;
    localparam logic [1:0] BAD = 2'b11;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  lat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_wr_en, mem_rd_en, mem_sign_ext;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_sign     (req_sign),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_size     (mem_size),
        .mem_sign_ext (mem_sign_ext),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Data memory: 256 bytes, aliased on the low address byte, sized/extended reads.
    logic [7:0]  pre [256];
    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    bit          mem_loaded = 1'b0;
    logic [31:0] mw;

    always_comb begin
        mw = {mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
              mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};
        case (mem_size)
            B:       mem_rdata = {{24{mem_sign_ext & mw[7]}}, mw[7:0]};
            H:       mem_rdata = {{16{mem_sign_ext & mw[15]}}, mw[15:0]};
            default: mem_rdata = mw;
        endcase
    end

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= pre[i];
            mem_loaded <= 1'b1;
        end else if (mem_wr_en) begin
            mem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_size != B) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            if (mem_size == W) begin
                mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    int   n_checks = 0;
    int   n_pass   = 0;
    acc_t exp_acc [$];
    rsp_t exp_rsp [$];

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Reference: byte-addressed semantics, independent of how the DUT sequences them.
    task automatic model_req(input logic we, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int          nb;
        bit          mis;
        bit          err;
        logic [31:0] val;
        logic [7:0]  ad;
        acc_t        a;
        rsp_t        r;
        nb  = (size == BAD) ? 0 : (1 << size);
        mis = (size == H && addr[0]) || (size == W && addr[1:0] != 2'b00);
        err = (size == BAD) || (mis && !SPLIT);
        r.err   = err;
        r.rdata = 32'd0;
        r.lat   = 8'd1;
        if (!err) begin
            val = 32'd0;
            for (int i = 0; i < nb; i++) begin
                ad = 8'(addr + 32'(i));
                if (we) ref_mem[ad] = wdata[8*i +: 8];
                else    val[8*i +: 8] = ref_mem[ad];
            end
            if (!we && sign && nb < 4 && val[8*nb-1])
                val = val | ~((32'd1 << (8*nb)) - 32'd1);
            r.rdata = we ? 32'd0 : val;
            if (mis) begin
                for (int i = 0; i < nb; i++) begin
                    a.we    = we;
                    a.size  = B;
                    a.sign  = 1'b0;
                    a.addr  = addr + 32'(i);
                    a.wdata = we ? 32'(wdata[8*i +: 8]) : 32'd0;
                    exp_acc.push_back(a);
                end
                r.lat = 8'(1 + nb);
            end else begin
                a.we    = we;
                a.size  = size;
                a.sign  = sign;
                a.addr  = addr;
                a.wdata = we ? wdata : 32'd0;
                exp_acc.push_back(a);
                r.lat = 8'd2;
            end
        end
        exp_rsp.push_back(r);
    endtask

    // Monitor: pops expected accesses/responses as the DUT presents them.
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_mem = 0;
    bit   lat_done = 1'b0;
    acc_t m_acc;
    rsp_t m_rsp;

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (req_valid && req_ready) acc_cyc = cyc;
            if (mem_wr_en || mem_rd_en) begin
                n_mem++;
                check("mem_en_both", 128'(mem_wr_en & mem_rd_en), 128'(0));
                if (exp_acc.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_mem_access: addr 0x%0h we %0d", mem_addr, mem_wr_en);
                end else begin
                    m_acc = exp_acc.pop_front();
                    check("mem_access",
                          128'({mem_wr_en, mem_size, mem_sign_ext, mem_addr, mem_wr_en ? mem_wdata : 32'd0}),
                          128'(m_acc));
                end
            end
            if (resp_valid) begin
                if (exp_rsp.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: err %0d rdata 0x%0h", resp_err, resp_rdata);
                end else begin
                    m_rsp = exp_rsp[0];
                    if (!lat_done) begin
                        check("resp_latency", 128'(cyc - acc_cyc), 128'(m_rsp.lat));
                        lat_done = 1'b1;
                    end
                    check("resp_data", 128'({resp_err, resp_rdata}), 128'({m_rsp.err, m_rsp.rdata}));
                    check("req_ready_busy", 128'(req_ready), 128'(0));
                    if (resp_ready) begin
                        void'(exp_rsp.pop_front());
                        lat_done = 1'b0;
                    end
                end
            end
        end
    end

    logic [103:0] outs;
    assign outs = {req_ready, resp_valid, resp_err, resp_rdata, mem_wr_en, mem_rd_en,
                   mem_size, mem_sign_ext, mem_addr, mem_wdata};

    task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        int k;
        @(negedge clk);
        check("req_ready_idle", 128'(req_ready), 128'(1));
        model_req(we, size, sign, addr, wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_sign   = sign;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b0;
        @(negedge clk);
        k = 0;
        // Busy phase: noise on the request side must be ignored.
        while (exp_rsp.size() != 0 && k < 200) begin
            req_valid  = 1'($urandom);
            req_we     = 1'($urandom);
            req_size   = 2'($urandom);
            req_sign   = 1'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            resp_ready = (k < hold) ? 1'b0 : 1'($urandom);
            k++;
            @(negedge clk);
        end
        if (exp_rsp.size() != 0) begin
            n_checks++;
            $display("FAIL resp_timeout: %0d responses outstanding", exp_rsp.size());
            exp_rsp.delete();
            exp_acc.delete();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
    endtask

    int          m0;
    logic [1:0]  rsz;
    logic [31:0] raddr;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            pre[i]     = 8'($urandom);
            ref_mem[i] = pre[i];
        end
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", 128'(outs), 128'({1'b1, 103'd0}));
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b1, W, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        do_req(1'b0, W, 1'b0, 32'h10, 32'h0, 0);

        do_req(1'b1, B, 1'b0, 32'h20, 32'h0000_0080, 0);
        do_req(1'b0, B, 1'b1, 32'h20, 32'h0, 0);
        do_req(1'b0, B, 1'b0, 32'h20, 32'h0, 0);

        m0 = n_mem;
        do_req(1'b0, W, 1'b0, 32'h13, 32'h0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("misaligned_load_accesses", 128'(n_mem - m0), 128'(4));
`else
        check("misaligned_no_access", 128'(n_mem - m0), 128'(0));
`endif

        m0 = n_mem;
        do_req(1'b1, W, 1'b0, 32'h13, 32'h11223344, 0);
        do_req(1'b0, W, 1'b0, 32'h13, 32'h0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("split_store_load_accesses", 128'(n_mem - m0), 128'(8));
`else
        check("misaligned_store_no_access", 128'(n_mem - m0), 128'(0));
`endif

        m0 = n_mem;
        do_req(1'b0, BAD, 1'b0, 32'h40, 32'h0, 0);
        check("bad_size_no_access", 128'(n_mem - m0), 128'(0));

        do_req(1'b0, W, 1'b0, 32'h10, 32'h0, 5);
        do_req(1'b1, H, 1'b0, 32'hFFFF_FFFF, 32'h0000_A55A, 2);
        do_req(1'b0, H, 1'b1, 32'hFFFF_FFFF, 32'h0, 0);
        do_req(1'b1, H, 1'b0, 32'h32, 32'h1234_8001, 0);
        do_req(1'b0, H, 1'b1, 32'h32, 32'h0, 0);

        // Reset while an access is in flight.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = W; req_sign = 1'b1; req_wdata = 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
        req_addr = 32'h21;
`else
        req_addr = 32'h20;
`endif
        @(negedge clk);
        req_valid = 1'b0;
        check("in_flight_read", 128'(mem_rd_en), 128'(1));
        rst_n = 1'b0;
        #1 check("async_reset_mid_op", 128'(outs), 128'({1'b1, 103'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        exp_acc.delete();
        exp_rsp.delete();
        do_req(1'b0, W, 1'b1, 32'h10, 32'h0, 0);

        for (int n = 0; n < 60; n++) begin
            rsz   = ($urandom_range(0, 9) == 0) ? BAD : 2'($urandom_range(0, 2));
            raddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            do_req(1'($urandom), rsz, 1'($urandom), raddr, $urandom, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("acc_queue_drained", 128'(exp_acc.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
